// File: rtl/execute_muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/execute_muldiv_if.sv
// Execute-stage M-extension request/result bundle; slave side is the muldiv unit.
interface execute_muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      x_funct3;
  logic [XLEN-1:0] x_data_rs1;
  logic [XLEN-1:0] x_data_rs2;
  logic [4:0]      x_rd;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output start, flush, x_funct3, x_data_rs1, x_data_rs2, x_rd,
    input  stall_req, done, result, result_rd
  );

  modport slave (
    input  start, flush, x_funct3, x_data_rs1, x_data_rs2, x_rd,
    output stall_req, done, result, result_rd
  );

endinterface

// File: rtl/execute_muldiv_divider_core.sv
// Iterative restoring unsigned divider: one quotient bit per clock after start_i.
module divider_core #(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN:0]   rem_sh, diff;

  // The dividend shifts out of quo_q MSB-first while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d  = cnt_q + 1'b1;
      busy_d = (cnt_q != CW'(DIV_STEPS - 1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit with pipeline stall; define MULDIV_EARLY_OUT_EN to
// resolve divide-by-zero and signed overflow one edge after accept.
module execute_muldiv #(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input logic             clock,
  input logic             reset,
  execute_muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]      rd_q, rd_d, result_rd_q, result_rd_d;
  logic            done_q, done_d;
  logic            accept, early, div_start, div_busy;
  logic [XLEN-1:0] dvd_mag, dvs_mag, quo_mag, rem_mag, mul_res, div_res;
  logic signed [2*XLEN-1:0] a_ext, b_ext, prod;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic signed_div_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [XLEN-1:0] a, b);
    return (b == '0) || (signed_div_op(f3) && (a == INT_MIN) && (b == '1));
  endfunction

  function automatic logic [XLEN-1:0] special_val(input logic [2:0] f3, input logic [XLEN-1:0] a, b);
    if (b == '0) return rem_op(f3) ? a : DIV_BY_ZERO_Q;
    return rem_op(f3) ? '0 : INT_MIN;
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  assign accept        = bus.start & ~bus.flush & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign bus.stall_req = accept | (state_q == S_MUL) | (state_q == S_DIV);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = accept & is_div_op(bus.x_funct3) & is_special(bus.x_funct3, bus.x_data_rs1, bus.x_data_rs2);
`else
  assign early = 1'b0;
`endif

  assign div_start = accept & is_div_op(bus.x_funct3) & ~early;
  assign dvd_mag   = negate_if(signed_div_op(bus.x_funct3) & bus.x_data_rs1[XLEN-1], bus.x_data_rs1);
  assign dvs_mag   = negate_if(signed_div_op(bus.x_funct3) & bus.x_data_rs2[XLEN-1], bus.x_data_rs2);

  divider_core #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) u_div (
    .clock       (clock),
    .reset       (reset),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .busy_o      (div_busy),
    .quotient_o  (quo_mag),
    .remainder_o (rem_mag)
  );

  always_comb begin
    a_ext   = {{XLEN{a_q[XLEN-1] & ((f3_q == F3_MULH) | (f3_q == F3_MULHSU))}}, a_q};
    b_ext   = {{XLEN{b_q[XLEN-1] & (f3_q == F3_MULH)}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Special cases bypass the magnitude path so the -x/0 quotient is not sign-flipped.
  always_comb begin
    if (is_special(f3_q, a_q, b_q))
      div_res = special_val(f3_q, a_q, b_q);
    else if (rem_op(f3_q))
      div_res = negate_if(signed_div_op(f3_q) & a_q[XLEN-1], rem_mag);
    else
      div_res = negate_if(signed_div_op(f3_q) & (a_q[XLEN-1] ^ b_q[XLEN-1]), quo_mag);
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          f3_d    = bus.x_funct3;
          a_d     = bus.x_data_rs1;
          b_d     = bus.x_data_rs2;
          rd_d    = bus.x_rd;
          state_d = div_start ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        result_d    = is_div_op(f3_q) ? div_res : mul_res;
        result_rd_d = rd_q;
        done_d      = 1'b1;
        state_d     = S_DONE;
      end
      S_DIV: begin
        if (!div_busy) begin
          result_d    = div_res;
          result_rd_d = rd_q;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d     = S_IDLE;
      result_d    = result_q;
      result_rd_d = result_rd_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      f3_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
      done_q      <= done_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_rd = result_rd_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized + directed bench for execute_muldiv against a cycle-level behavioural model.
module tb_execute_muldiv;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  execute_muldiv_if bus();
  execute_muldiv dut (.clock(clock), .reset(reset), .bus(bus));

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an M op from plain integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    ua = {32'd0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1;
    if (b == 32'd0) return SPEC_LAT;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_LAT;
    return 33;
  endfunction

  // Model: edges remaining until the pending result lands; 0 means idle/done.
  int          m_busy    = 0;
  logic        m_done    = 1'b0;
  logic [31:0] m_result  = 32'd0;
  logic [31:0] m_pend    = 32'd0;
  logic [4:0]  m_rd      = 5'd0;
  logic [4:0]  m_pend_rd = 5'd0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy   <= 0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
      m_rd     <= 5'd0;
    end else if (bus.flush) begin
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      m_done <= (m_busy == 1);
      if (m_busy == 1) begin
        m_result <= m_pend;
        m_rd     <= m_pend_rd;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_pend    <= ref_op(bus.x_funct3, bus.x_data_rs1, bus.x_data_rs2);
        m_pend_rd <= bus.x_rd;
        m_busy    <= lat_of(bus.x_funct3, bus.x_data_rs1, bus.x_data_rs2);
      end
    end
  end

  always @(negedge clock) begin
    logic exp_stall;
    exp_stall = (m_busy > 0) || (bus.start && !bus.flush);
    check("stall_req", 32'(bus.stall_req), 32'(exp_stall));
    check("done", 32'(bus.done), 32'(m_done));
    check("result", bus.result, m_result);
    check("result_rd", 32'(bus.result_rd), 32'(m_rd));
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start      = 1'b1;
    bus.flush      = 1'b0;
    bus.x_funct3   = f3;
    bus.x_data_rs1 = a;
    bus.x_data_rs2 = b;
    bus.x_rd       = rd;
  endtask

  // Returns edges from the accept edge to the edge that raised done.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    drive(f3, a, b, rd);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL op_timeout: got no done expected done within 100 edges (f3=%0d)", f3);
    end
  endtask

  task automatic finish_op();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("stall_in_done_cycle", 32'(bus.stall_req), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, dones;
    logic [2:0] f3;
    logic [31:0] a, b;

    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.x_funct3   = 3'd0;
    bus.x_data_rs1 = 32'd0;
    bus.x_data_rs2 = 32'd0;
    bus.x_rd       = 5'd0;

    check("pin_mul", ref_op(F3_MUL, 32'd7, 32'hFFFF_FFFA), 32'hFFFF_FFD6);
    check("pin_mulh", ref_op(F3_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_rem", ref_op(F3_REM, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    check("pin_remu0", ref_op(F3_REMU, 32'd5, 32'd0), 32'd5);
    check("pin_div_neg0", ref_op(F3_DIV, 32'hFFFF_FFFB, 32'd0), 32'hFFFF_FFFF);

    repeat (3) @(posedge clock);
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", 32'(bus.result_rd), 32'd0);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    do_op(F3_MUL, 32'd7, 32'hFFFF_FFFA, 5'd5, lat);
    check("mul_res", bus.result, 32'hFFFF_FFD6);
    check("mul_rd", 32'(bus.result_rd), 32'd5);
    check("mul_lat", 32'(lat), 32'd1);
    do_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, lat);
    check("mulh_res", bus.result, 32'h4000_0000);
    check("b2b_mulh_lat", 32'(lat), 32'd1);
    do_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, lat);
    check("mulhu_res", bus.result, 32'hFFFF_FFFE);
    check("b2b_mulhu_lat", 32'(lat), 32'd1);
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, lat);
    check("mulhsu_res", bus.result, 32'hFFFF_FFFF);
    finish_op();

    do_op(F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd10, lat);
    check("div_res", bus.result, 32'hFFFF_FFFA);
    check("div_lat", 32'(lat), 32'd33);
    finish_op();
    do_op(F3_REM, 32'hFFFF_FFEC, 32'd3, 5'd11, lat);
    check("rem_res", bus.result, 32'hFFFF_FFFE);
    check("rem_lat", 32'(lat), 32'd33);
    finish_op();
    do_op(F3_DIV, 32'd5, 32'd0, 5'd1, lat);
    check("div0_res", bus.result, 32'hFFFF_FFFF);
    check("div0_lat", 32'(lat), 32'(SPEC_LAT));
    finish_op();
    do_op(F3_REMU, 32'd5, 32'd0, 5'd2, lat);
    check("remu0_res", bus.result, 32'd5);
    finish_op();
    do_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat);
    check("divovf_res", bus.result, 32'h8000_0000);
    check("divovf_lat", 32'(lat), 32'(SPEC_LAT));
    finish_op();
    do_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat);
    check("removf_res", bus.result, 32'd0);
    finish_op();
    do_op(F3_DIVU, 32'd100, 32'd7, 5'd12, lat);
    check("divu_res", bus.result, 32'd14);
    check("divu_lat", 32'(lat), 32'd33);
    finish_op();

    repeat (2) @(posedge clock);
    #1;
    drive(F3_DIVU, 32'd1000, 32'd3, 5'd9);
    repeat (11) @(posedge clock);
    #1;
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check("flush_stall", 32'(bus.stall_req), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_kept", bus.result, 32'd14);
    check("flush_rd_kept", 32'(bus.result_rd), 32'd12);
    do_op(F3_MUL, 32'd3, 32'd4, 5'd13, lat);
    check("post_flush_mul", bus.result, 32'd12);
    finish_op();

    drive(F3_DIVU, 32'hDEAD_BEEF, 32'd17, 5'd14);
    repeat (21) @(posedge clock);
    #1;
    bus.start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("areset_done", 32'(bus.done), 32'd0);
    check("areset_result", bus.result, 32'd0);
    check("areset_stall", 32'(bus.stall_req), 32'd0);
    check("areset_rd", 32'(bus.result_rd), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 80; k++) begin
      f3 = 3'($urandom % 8);
      a  = rand_operand();
      b  = rand_operand();
      if ($urandom % 8 == 0) begin
        drive(f3, a, b, 5'($urandom));
        repeat ($urandom_range(1, 20)) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
      end else begin
        do_op(f3, a, b, 5'($urandom), lat);
        check("rand_lat", 32'(lat), 32'(lat_of(f3, a, b)));
        if ($urandom % 2 == 0) begin
          finish_op();
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1;
        end
      end
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
